// File: rtl/hpdcache_mem_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : hpdcache_mem_wr_arbiter
//  Brief   : Shares the memory write interface between the write buffer (r0)
//            and the uncacheable/AMO path (r1); data follows the grant order.
//  Revision: 1.0 - initial release
// ============================================================================
module hpdcache_mem_wr_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 49,
    parameter int unsigned ID_WIDTH    = 8,
    parameter int unsigned DATA_WIDTH  = 128,
    parameter int unsigned ORDER_DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    r0_req_valid_i,
    output logic                    r0_req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   r0_req_addr_i,
    input  logic [ID_WIDTH-2:0]     r0_req_id_i,
    input  logic                    r0_req_uc_i,
    input  logic                    r0_data_valid_i,
    output logic                    r0_data_ready_o,
    input  logic [DATA_WIDTH-1:0]   r0_data_i,
    input  logic [DATA_WIDTH/8-1:0] r0_be_i,
    output logic                    r0_resp_valid_o,
    output logic [ID_WIDTH-2:0]     r0_resp_id_o,
    output logic                    r0_resp_error_o,

    input  logic                    r1_req_valid_i,
    output logic                    r1_req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   r1_req_addr_i,
    input  logic [ID_WIDTH-2:0]     r1_req_id_i,
    input  logic                    r1_req_uc_i,
    input  logic                    r1_data_valid_i,
    output logic                    r1_data_ready_o,
    input  logic [DATA_WIDTH-1:0]   r1_data_i,
    input  logic [DATA_WIDTH/8-1:0] r1_be_i,
    output logic                    r1_resp_valid_o,
    output logic [ID_WIDTH-2:0]     r1_resp_id_o,
    output logic                    r1_resp_error_o,

    output logic                    mem_req_valid_o,
    input  logic                    mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr_o,
    output logic [ID_WIDTH-1:0]     mem_req_id_o,
    output logic                    mem_req_cacheable_o,

    output logic                    mem_data_valid_o,
    input  logic                    mem_data_ready_i,
    output logic [DATA_WIDTH-1:0]   mem_data_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic                    mem_data_last_o,

    input  logic                    mem_resp_valid_i,
    output logic                    mem_resp_ready_o,
    input  logic [ID_WIDTH-1:0]     mem_resp_id_i,
    input  logic                    mem_resp_error_i
);

    localparam int unsigned        c_PTR_W = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;
    localparam int unsigned        c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(ORDER_DEPTH);

    logic                   r_rr_ptr;
    logic                   r_lock;
    logic                   r_lock_sel;
    logic [ORDER_DEPTH-1:0] r_order;
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;

    logic w_gnt_sel;
    logic w_gnt_valid;
    logic w_fifo_full;
    logic w_fifo_empty;
    logic w_meta_hs;
    logic w_data_active;
    logic w_data_sel;
    logic w_data_hs;
    logic w_push;
    logic w_pop;

    // A locked grant keeps its owner until the memory accepts the request.
    always_comb begin
        w_gnt_sel = 1'b0;
        if (r_lock) begin
            w_gnt_sel = r_lock_sel;
        end else if (r0_req_valid_i && r1_req_valid_i) begin
            w_gnt_sel = r_rr_ptr;
        end else begin
            w_gnt_sel = r1_req_valid_i;
        end
    end

    assign w_gnt_valid  = w_gnt_sel ? r1_req_valid_i : r0_req_valid_i;
    assign w_fifo_full  = (r_count == c_DEPTH);
    assign w_fifo_empty = (r_count == '0);

    assign mem_req_valid_o     = w_gnt_valid & ~w_fifo_full;
    assign w_meta_hs           = mem_req_valid_o & mem_req_ready_i;
    assign mem_req_addr_o      = w_gnt_sel ? r1_req_addr_i : r0_req_addr_i;
    assign mem_req_id_o        = {w_gnt_sel, (w_gnt_sel ? r1_req_id_i : r0_req_id_i)};
    assign mem_req_cacheable_o = ~(w_gnt_sel ? r1_req_uc_i : r0_req_uc_i);

    // A grant only exists while some requester is valid, so idle readies stay low.
    assign r0_req_ready_o = ~w_gnt_sel & w_gnt_valid & mem_req_ready_i & ~w_fifo_full;
    assign r1_req_ready_o =  w_gnt_sel & w_gnt_valid & mem_req_ready_i & ~w_fifo_full;

    // Empty order FIFO: data may bypass to the requester granted this very cycle.
    assign w_data_active    = ~w_fifo_empty | w_meta_hs;
    assign w_data_sel       = w_fifo_empty ? w_gnt_sel : r_order[r_rd_ptr];
    assign mem_data_valid_o = w_data_active & (w_data_sel ? r1_data_valid_i : r0_data_valid_i);
    assign mem_data_o       = w_data_sel ? r1_data_i : r0_data_i;
    assign mem_be_o         = w_data_sel ? r1_be_i : r0_be_i;
    assign mem_data_last_o  = 1'b1;
    assign r0_data_ready_o  = w_data_active & ~w_data_sel & mem_data_ready_i;
    assign r1_data_ready_o  = w_data_active &  w_data_sel & mem_data_ready_i;
    assign w_data_hs        = mem_data_valid_o & mem_data_ready_i;

    assign w_pop  = w_data_hs & ~w_fifo_empty;
    assign w_push = w_meta_hs & ~(w_fifo_empty & w_data_hs);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_ptr   <= 1'b0;
            r_lock     <= 1'b0;
            r_lock_sel <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_meta_hs) begin
                r_lock   <= 1'b0;
                r_rr_ptr <= ~w_gnt_sel;
            end else if (mem_req_valid_o) begin
                r_lock     <= 1'b1;
                r_lock_sel <= w_gnt_sel;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_order[r_wr_ptr] <= w_gnt_sel;
        end
    end

    assign mem_resp_ready_o = 1'b1;
    assign r0_resp_valid_o  = mem_resp_valid_i & ~mem_resp_id_i[ID_WIDTH-1];
    assign r1_resp_valid_o  = mem_resp_valid_i &  mem_resp_id_i[ID_WIDTH-1];
    assign r0_resp_id_o     = mem_resp_id_i[ID_WIDTH-2:0];
    assign r1_resp_id_o     = mem_resp_id_i[ID_WIDTH-2:0];
    assign r0_resp_error_o  = mem_resp_error_i;
    assign r1_resp_error_o  = mem_resp_error_i;

endmodule
`default_nettype wire

// File: tb/tb_hpdcache_mem_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_hpdcache_mem_wr_arbiter
//  Brief   : Randomised scoreboard bench for hpdcache_mem_wr_arbiter.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_hpdcache_mem_wr_arbiter;

    localparam int AW    = 49;
    localparam int IW    = 8;
    localparam int DW    = 128;
    localparam int BW    = DW / 8;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [IW-2:0]   id;
        logic            uc;
    } req_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [BW-1:0] be;
    } dat_t;

    logic clk = 1'b0;
    logic rst;

    logic            rq_v    [2];
    logic            rq_rdy  [2];
    logic [AW-1:0]   rq_addr [2];
    logic [IW-2:0]   rq_id   [2];
    logic            rq_uc   [2];
    logic            dt_v    [2];
    logic            dt_rdy  [2];
    logic [DW-1:0]   dt_data [2];
    logic [BW-1:0]   dt_be   [2];
    logic            rs_v    [2];
    logic [IW-2:0]   rs_id   [2];
    logic            rs_err  [2];

    logic            mem_req_valid, mem_req_ready, mem_req_cacheable;
    logic [AW-1:0]   mem_req_addr;
    logic [IW-1:0]   mem_req_id;
    logic            mem_data_valid, mem_data_ready, mem_data_last;
    logic [DW-1:0]   mem_data;
    logic [BW-1:0]   mem_be;
    logic            mem_resp_valid, mem_resp_ready, mem_resp_error;
    logic [IW-1:0]   mem_resp_id;

    always #5 clk = ~clk;

    hpdcache_mem_wr_arbiter #(
        .ADDR_WIDTH (AW),
        .ID_WIDTH   (IW),
        .DATA_WIDTH (DW),
        .ORDER_DEPTH(DEPTH)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .r0_req_valid_i     (rq_v[0]),
        .r0_req_ready_o     (rq_rdy[0]),
        .r0_req_addr_i      (rq_addr[0]),
        .r0_req_id_i        (rq_id[0]),
        .r0_req_uc_i        (rq_uc[0]),
        .r0_data_valid_i    (dt_v[0]),
        .r0_data_ready_o    (dt_rdy[0]),
        .r0_data_i          (dt_data[0]),
        .r0_be_i            (dt_be[0]),
        .r0_resp_valid_o    (rs_v[0]),
        .r0_resp_id_o       (rs_id[0]),
        .r0_resp_error_o    (rs_err[0]),
        .r1_req_valid_i     (rq_v[1]),
        .r1_req_ready_o     (rq_rdy[1]),
        .r1_req_addr_i      (rq_addr[1]),
        .r1_req_id_i        (rq_id[1]),
        .r1_req_uc_i        (rq_uc[1]),
        .r1_data_valid_i    (dt_v[1]),
        .r1_data_ready_o    (dt_rdy[1]),
        .r1_data_i          (dt_data[1]),
        .r1_be_i            (dt_be[1]),
        .r1_resp_valid_o    (rs_v[1]),
        .r1_resp_id_o       (rs_id[1]),
        .r1_resp_error_o    (rs_err[1]),
        .mem_req_valid_o    (mem_req_valid),
        .mem_req_ready_i    (mem_req_ready),
        .mem_req_addr_o     (mem_req_addr),
        .mem_req_id_o       (mem_req_id),
        .mem_req_cacheable_o(mem_req_cacheable),
        .mem_data_valid_o   (mem_data_valid),
        .mem_data_ready_i   (mem_data_ready),
        .mem_data_o         (mem_data),
        .mem_be_o           (mem_be),
        .mem_data_last_o    (mem_data_last),
        .mem_resp_valid_i   (mem_resp_valid),
        .mem_resp_ready_o   (mem_resp_ready),
        .mem_resp_id_i      (mem_resp_id),
        .mem_resp_error_i   (mem_resp_error)
    );

    int checks   = 0;
    int failures = 0;

    // Scoreboard: pushed by the requester driver, popped by the monitor.
    req_t exp_req  [2][$];
    dat_t exp_data [2][$];
    dat_t pend     [2][$];
    bit   hs_req   [2];
    bit   hs_dat   [2];

    // Reference model: priority requester, held grant (-1 = none), grant order list.
    int m_ptr  = 0;
    int m_lock = -1;
    int m_order[$];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        if (failures <= 40) $display("FAIL %s actual=empty required=entry t=%0t", nm, $time);
    endtask

    always @(negedge clk) begin
        int  sel, own;
        bit  gval, full, emv, meta_hs, edv, data_hs, was_empty, exp_v;
        #3;
        sel  = (m_lock >= 0) ? m_lock : ((rq_v[0] && rq_v[1]) ? m_ptr : (rq_v[1] ? 1 : 0));
        gval = rq_v[sel];
        full = (m_order.size() == DEPTH);
        emv  = gval && !full;
        meta_hs = emv && mem_req_ready;
        own  = (m_order.size() > 0) ? m_order[0] : (meta_hs ? sel : -1);
        edv  = (own >= 0) && dt_v[own];
        data_hs = edv && mem_data_ready;

        chk("mem_req_valid", {127'd0, mem_req_valid}, {127'd0, emv});
        for (int n = 0; n < 2; n++) begin
            chk($sformatf("r%0d_req_ready", n), {127'd0, rq_rdy[n]},
                {127'd0, (sel == n) && emv && mem_req_ready});
            chk($sformatf("r%0d_data_ready", n), {127'd0, dt_rdy[n]},
                {127'd0, (own == n) && mem_data_ready});
        end
        if (emv) begin
            chk("req_owner", {127'd0, mem_req_id[IW-1]}, DW'(sel));
            if (exp_req[sel].size() == 0) fail_now("req_payload");
            else begin
                chk("req_addr", DW'(mem_req_addr), DW'(exp_req[sel][0].addr));
                chk("req_id", DW'(mem_req_id[IW-2:0]), DW'(exp_req[sel][0].id));
                chk("req_cacheable", {127'd0, mem_req_cacheable}, {127'd0, ~exp_req[sel][0].uc});
            end
        end
        chk("mem_data_valid", {127'd0, mem_data_valid}, {127'd0, edv});
        if (edv) begin
            if (exp_data[own].size() == 0) fail_now("data_payload");
            else begin
                chk("mem_data", mem_data, exp_data[own][0].data);
                chk("mem_be", DW'(mem_be), DW'(exp_data[own][0].be));
            end
        end
        chk("data_last", {127'd0, mem_data_last}, 128'd1);
        chk("resp_ready", {127'd0, mem_resp_ready}, 128'd1);
        for (int n = 0; n < 2; n++) begin
            exp_v = mem_resp_valid && (mem_resp_id[IW-1] == n[0]);
            chk($sformatf("r%0d_resp_valid", n), {127'd0, rs_v[n]}, {127'd0, exp_v});
            if (exp_v) begin
                chk($sformatf("r%0d_resp_id", n), DW'(rs_id[n]), DW'(mem_resp_id[IW-2:0]));
                chk($sformatf("r%0d_resp_error", n), {127'd0, rs_err[n]}, {127'd0, mem_resp_error});
            end
        end

        for (int n = 0; n < 2; n++) begin
            hs_req[n] = rq_v[n] && rq_rdy[n];
            hs_dat[n] = dt_v[n] && dt_rdy[n];
        end
        if (meta_hs && exp_req[sel].size() > 0) void'(exp_req[sel].pop_front());
        if (data_hs && exp_data[own].size() > 0) void'(exp_data[own].pop_front());

        if (rst) begin
            m_ptr  = 0;
            m_lock = -1;
            m_order.delete();
        end else begin
            was_empty = (m_order.size() == 0);
            if (data_hs && !was_empty) void'(m_order.pop_front());
            if (meta_hs) begin
                m_lock = -1;
                m_ptr  = 1 - sel;
                if (!(was_empty && data_hs)) m_order.push_back(sel);
            end else if (emv) begin
                m_lock = sel;
            end
        end
    end

    task automatic new_txn(input int n);
        req_t        r;
        dat_t        d;
        logic [63:0] t;
        t      = {$urandom, $urandom};
        r.addr = t[AW-1:0];
        r.id   = IW'($urandom) & 7'h7f;
        r.uc   = $urandom_range(1);
        d.data = {$urandom, $urandom, $urandom, $urandom};
        d.be   = BW'($urandom);
        exp_req[n].push_back(r);
        exp_data[n].push_back(d);
        pend[n].push_back(d);
        rq_v[n]    = 1'b1;
        rq_addr[n] = r.addr;
        rq_id[n]   = r.id;
        rq_uc[n]   = r.uc;
    endtask

    task automatic drive(input bit do_rst, input bit quiet, input bit force_both,
                         input int p_req, input int p_mrdy, input int p_drdy);
        for (int n = 0; n < 2; n++) begin
            if (hs_req[n]) rq_v[n] = 1'b0;
            if (hs_dat[n]) begin
                dt_v[n] = 1'b0;
                if (pend[n].size() > 0) void'(pend[n].pop_front());
            end
            hs_req[n] = 1'b0;
            hs_dat[n] = 1'b0;
        end
        rst = do_rst;
        if (do_rst || quiet) begin
            for (int n = 0; n < 2; n++) begin
                rq_v[n] = 1'b0;
                dt_v[n] = 1'b0;
                if (do_rst) begin
                    exp_req[n].delete();
                    exp_data[n].delete();
                    pend[n].delete();
                end
            end
            mem_resp_valid = 1'b0;
            mem_req_ready  = $urandom_range(1);
            mem_data_ready = $urandom_range(1);
            return;
        end
        for (int n = 0; n < 2; n++) begin
            if (!rq_v[n] && (force_both || $urandom_range(99) < p_req)) new_txn(n);
            if (!dt_v[n] && pend[n].size() > 0 && $urandom_range(99) < 60) begin
                dt_v[n]    = 1'b1;
                dt_data[n] = pend[n][0].data;
                dt_be[n]   = pend[n][0].be;
            end
        end
        mem_req_ready  = ($urandom_range(99) < p_mrdy);
        mem_data_ready = ($urandom_range(99) < p_drdy);
        mem_resp_valid = ($urandom_range(99) < 30);
        mem_resp_id    = IW'($urandom);
        mem_resp_error = $urandom_range(1);
    endtask

    initial begin
        int phase;
        rst = 1'b1;
        mem_req_ready = 1'b0; mem_data_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_id = '0; mem_resp_error = 1'b0;
        for (int n = 0; n < 2; n++) begin
            rq_v[n] = 1'b0; rq_addr[n] = '0; rq_id[n] = '0; rq_uc[n] = 1'b0;
            dt_v[n] = 1'b0; dt_data[n] = '0; dt_be[n] = '0;
            hs_req[n] = 1'b0; hs_dat[n] = 1'b0;
        end
        repeat (2) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 1'b0, 0, 0, 0);
        end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            phase = (cyc / 250) % 4;
            if (cyc == 2740)
                drive(1'b1, 1'b1, 1'b0, 0, 0, 0);
            else if (cyc == 2741 || cyc < 2)
                drive(1'b0, 1'b1, 1'b0, 0, 0, 0);
            else if (cyc == 2742 || cyc == 2)
                drive(1'b0, 1'b0, 1'b1, 0, 100, 100);
            else if (phase == 0)
                drive(1'b0, 1'b0, 1'b0, 85, 100, 100);
            else if (phase == 1)
                drive(1'b0, 1'b0, 1'b0, 60, 30, 70);
            else if (phase == 2)
                drive(1'b0, 1'b0, 1'b0, 70, 80, 5);
            else
                drive(1'b0, 1'b0, 1'b0, 50, 50, 50);
            if (cyc == 10) begin
                mem_resp_valid = 1'b1;
                mem_resp_id    = 8'h85;
                mem_resp_error = 1'b1;
            end
        end
        @(negedge clk);
        #4;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
